// File: rtl/imem_loader_pkg.sv
// Shared types and default geometry for the instruction-memory loader.
// Default geometry: 32 words of 32 bits, 4 byte lanes per word.
package imem_loader_pkg;

   localparam int DEF_DEPTH      = 32;
   localparam int DEF_AW         = 5;
   localparam int DEF_DW         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_array.sv
// Instruction array: one synchronous write port for the loader and one
// asynchronous read port for the core's fetch stage.
module imem_loader_array #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto RAM; contents survive reset.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: header N, N little-endian words, XOR checksum.
// Keeps the core held until a load completes with a matching checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          core_hold,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   words_written
);

   localparam int               BI        = $clog2(BYTES_PER_WORD);
   localparam logic [BI-1:0]    LAST_LANE = BI'(BYTES_PER_WORD - 1);
   localparam logic [8:0]       DEPTH_9   = 9'(DEPTH);

   state_t        state, next_state;
   logic [BI-1:0] byte_idx;
   logic [AW-1:0] waddr;
   logic [23:0]   asm_q;
   logic [7:0]    xor_q;
   logic [AW:0]   n_words;
   logic [AW:0]   ww_inc;
   logic          accept, word_we, last_word, enter_hdr, hdr_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      next_state = state;
      unique case (state)
         IDLE:      if (start)  next_state = HDR;
         HDR:       if (accept) next_state = hdr_ok ? DATA : ERR;
         DATA:      if (last_word) next_state = CHK;
         CHK:       if (accept) next_state = (in_data == xor_q) ? DONE : ERR;
         DONE, ERR: if (start)  next_state = HDR;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == HDR) || (state == DATA) || (state == CHK);
      accept    = in_valid && in_ready;
      enter_hdr = start && ((state == IDLE) || (state == DONE) || (state == ERR));
      hdr_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH_9);
      word_we   = accept && (state == DATA) && (byte_idx == LAST_LANE);
      ww_inc    = words_written + (AW+1)'(1);
      last_word = word_we && (ww_inc == n_words);
   end

   // Status flags are registered off next_state so they change with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_hold <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         core_hold <= (next_state != DONE);
         load_done <= (next_state == DONE);
         load_err  <= (next_state == ERR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx      <= '0;
         waddr         <= '0;
         asm_q         <= '0;
         xor_q         <= '0;
         n_words       <= '0;
         words_written <= '0;
      end else if (enter_hdr) begin
         byte_idx      <= '0;
         waddr         <= '0;
         asm_q         <= '0;
         xor_q         <= '0;
         words_written <= '0;
      end else if (accept) begin
         if (state == HDR) begin
            n_words <= (AW+1)'(in_data);
         end else if (state == DATA) begin
            xor_q    <= xor_q ^ in_data;
            byte_idx <= byte_idx + BI'(1);
            case (byte_idx)
               BI'(0):  asm_q[7:0]   <= in_data;
               BI'(1):  asm_q[15:8]  <= in_data;
               BI'(2):  asm_q[23:16] <= in_data;
               default: ;
            endcase
            if (word_we) begin
               waddr         <= waddr + AW'(1);
               words_written <= ww_inc;
            end
         end
      end
   end

   // The last byte goes straight into the word; it is never held in asm_q.
   imem_loader_array #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_array (
      .clk     (clk),
      .we      (word_we),
      .waddr   (waddr),
      .wdata   (DW'({in_data, asm_q})),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load streams checked against a stream-level model
// of the expected flags and array contents.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        core_hold;
   logic        load_done;
   logic        load_err;
   logic [5:0]  words_written;

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_mem   [32];
   logic        ref_valid [32];

   logic [7:0]  s [$];
   logic        e_done, e_err;
   logic [5:0]  e_ww;

   imem_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .core_hold     (core_hold),
      .load_done     (load_done),
      .load_err      (load_err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total++;
         bad++;
         $error("FAIL ready_timeout: got in_ready=0, want 1 within 50 cycles");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // start_at: byte index before which an extra (ignored) start pulse is sent.
   task automatic send_stream(input logic [7:0] q [$], input int max_gap, input int start_at);
      pulse_start();
      foreach (q[i]) begin
         if (i == start_at) pulse_start();
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         send_byte(q[i]);
      end
   endtask

   // Stream-level model: header, N words, XOR of data bytes against trailer.
   task automatic model_load(input logic [7:0] q [$], output logic d, output logic e,
                             output logic [5:0] ww);
      int n;
      logic [7:0] x;
      n  = int'(q[0]);
      x  = 8'h00;
      ww = 6'd0;
      if (n == 0 || n > 32) begin
         d = 1'b0;
         e = 1'b1;
      end else begin
         for (int w = 0; w < n; w++) begin
            ref_mem[w]   = {q[4*w+4], q[4*w+3], q[4*w+2], q[4*w+1]};
            ref_valid[w] = 1'b1;
            x = x ^ q[4*w+1] ^ q[4*w+2] ^ q[4*w+3] ^ q[4*w+4];
         end
         ww = 6'(n);
         d  = (q[4*n+1] == x);
         e  = !d;
      end
   endtask

   task automatic check_mem();
      for (int i = 0; i < 32; i++) begin
         if (ref_valid[i]) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), rd_data, ref_mem[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic check_result(input string tag, input logic d, input logic e, input logic [5:0] ww);
      check({tag, ".load_done"},     32'(load_done),     32'(d));
      check({tag, ".load_err"},      32'(load_err),      32'(e));
      check({tag, ".core_hold"},     32'(core_hold),     32'(!d));
      check({tag, ".in_ready"},      32'(in_ready),      32'd0);
      check({tag, ".words_written"}, 32'(words_written), 32'(ww));
      check_mem();
   endtask

   task automatic build_random(input int n, input logic corrupt);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      s.delete();
      s.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         s.push_back(b);
      end
      s.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      rd_addr  = 5'd0;

      repeat (3) @(negedge clk);
      check("rst.core_hold",     32'(core_hold),     32'd1);
      check("rst.in_ready",      32'(in_ready),      32'd0);
      check("rst.load_done",     32'(load_done),     32'd0);
      check("rst.load_err",      32'(load_err),      32'd0);
      check("rst.words_written", 32'(words_written), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle.in_ready", 32'(in_ready), 32'd0);
      end

      // Good load from the reference stream.
      s = '{8'h02, 8'h80, 8'h81, 8'h20, 8'h00, 8'h01, 8'h82, 8'h21, 8'h00, 8'h83};
      send_stream(s, 0, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("good", e_done, e_err, e_ww);
      rd_addr = 5'd0; #1;
      check("good.addr0", rd_data, 32'h0020_8180);
      rd_addr = 5'd1; #1;
      check("good.addr1", rd_data, 32'h0021_8201);
      @(negedge clk);

      // Same stream, wrong checksum.
      s[9] = 8'h84;
      send_stream(s, 0, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("badchk", e_done, e_err, e_ww);

      // Bad headers: zero and above DEPTH.
      s = '{8'h00};
      send_stream(s, 0, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("hdr0", e_done, e_err, e_ww);
      s = '{8'h21};
      send_stream(s, 0, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("hdr33", e_done, e_err, e_ww);

      // Good load with bubbles between bytes.
      s = '{8'h02, 8'h80, 8'h81, 8'h20, 8'h00, 8'h01, 8'h82, 8'h21, 8'h00, 8'h83};
      send_stream(s, 3, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("gaps", e_done, e_err, e_ww);

      // Reset after five data bytes: one word committed, then back to IDLE.
      s = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      pulse_start();
      foreach (s[i]) send_byte(s[i]);
      reset = 1'b0;
      #1;
      ref_mem[0] = 32'hD4C3_B2A1;
      check("midrst.in_ready",      32'(in_ready),      32'd0);
      check("midrst.core_hold",     32'(core_hold),     32'd1);
      check("midrst.load_done",     32'(load_done),     32'd0);
      check("midrst.load_err",      32'(load_err),      32'd0);
      check("midrst.words_written", 32'(words_written), 32'd0);
      rd_addr = 5'd0; #1;
      check("midrst.addr0", rd_data, 32'hD4C3_B2A1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Good load, then a shorter reload with a stray start during DATA.
      s = '{8'h02, 8'h80, 8'h81, 8'h20, 8'h00, 8'h01, 8'h82, 8'h21, 8'h00, 8'h83};
      send_stream(s, 0, -1);
      model_load(s, e_done, e_err, e_ww);
      check_result("pre_reload", e_done, e_err, e_ww);
      s = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      send_stream(s, 1, 3);
      model_load(s, e_done, e_err, e_ww);
      check_result("reload", e_done, e_err, e_ww);
      rd_addr = 5'd0; #1;
      check("reload.addr0", rd_data, 32'h1234_5678);
      rd_addr = 5'd1; #1;
      check("reload.addr1", rd_data, 32'h0021_8201);
      @(negedge clk);

      // Randomized loads: random size, occasional bad checksum or header.
      for (int k = 0; k < 8; k++) begin
         int sel;
         sel = int'($urandom_range(7, 0));
         if (sel == 0) begin
            s.delete();
            s.push_back(8'(33 + $urandom_range(222, 0)));
         end else begin
            build_random(int'($urandom_range(32, 1)), sel < 3);
         end
         send_stream(s, 2, -1);
         model_load(s, e_done, e_err, e_ww);
         check_result($sformatf("rand%0d", k), e_done, e_err, e_ww);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
